// File: rtl/hack_rom_loader.sv
// -----------------------------------------------------------------------------
// hack_rom_loader
//
// Upstream loader for the Hack Computer's instruction ROM. Consumes a framed
// byte stream over a valid/ready handshake, assembles 16-bit instruction words
// (high byte first) and writes them sequentially into ROM starting at address 0.
// The Computer is held in reset until a load completes with a good checksum.
//
// Frame: 0xA5, LEN_HI, LEN_LO, LEN x {HI, LO}, CHK
//   CHK = 8-bit sum of LEN_HI, LEN_LO and all data bytes (start byte excluded).
//
// Parameters:
//   ADDR_W          ROM address width; at most 2**ADDR_W words per load
//   TIMEOUT_CYCLES  idle clocks allowed between bytes inside a frame
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   in_data    stream byte
//   in_valid   in_data valid this cycle
//   in_ready   always 1; every in_valid cycle consumes one byte
//   rom_we     ROM write strobe, one cycle per word
//   rom_addr   ROM write address
//   rom_wdata  ROM write data
//   cpu_reset  reset to the Computer; low only in DONE
//   done       load completed with a good checksum
//   error      load aborted (bad length, bad checksum, timeout)
// -----------------------------------------------------------------------------
module hack_rom_loader #(
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      START    = 8'hA5;
  localparam logic [31:0]     MAX_LEN  = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;

  state_t            r_state;
  logic [7:0]        r_len_hi;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic [ADDR_W:0]   r_count;   // words still to receive; must hold 2**ADDR_W
  logic [TMO_W-1:0]  r_tmo;

  logic              w_accept;
  logic              w_in_frame;
  logic              w_is_start;
  logic [15:0]       w_len;
  logic [7:0]        w_chk_next;

  // The loader never stalls: the ROM takes one write per cycle and a word
  // needs two bytes, so a write can never collide with the next one.
  assign in_ready   = 1'b1;
  assign w_accept   = in_valid & in_ready;
  assign w_is_start = (in_data == START);
  assign w_len      = {r_len_hi, in_data};
  assign w_chk_next = r_chk + in_data;
  assign w_in_frame = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                      (r_state == DATA_HI) || (r_state == DATA_LO) ||
                      (r_state == CHECK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_len_hi  <= '0;
      r_hi      <= '0;
      r_chk     <= '0;
      r_count   <= '0;
      r_tmo     <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; where a later statement in
      // this block assigns the same register, the later one wins. The defaults
      // and the strobe-following address bump below rely on that ordering.
      rom_we <= 1'b0;
      if (rom_we) rom_addr <= rom_addr + ADDR_W'(1);

      // Idle-gap counter: only meaningful while a frame is in progress.
      if (w_in_frame && !w_accept) r_tmo <= r_tmo + TMO_W'(1);
      else                         r_tmo <= '0;

      case (r_state)
        IDLE: begin
          if (w_accept && w_is_start) begin
            r_state  <= LEN_HI;
            r_chk    <= '0;
            r_count  <= '0;
            rom_addr <= '0;
          end
        end

        LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= in_data;
            r_chk    <= w_chk_next;
            r_state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (w_accept) begin
            r_chk   <= w_chk_next;
            r_count <= (ADDR_W + 1)'(w_len);
            if (32'(w_len) > MAX_LEN) begin
              r_state <= ERR;
              error   <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA_HI;
            end
          end
        end

        DATA_HI: begin
          if (w_accept) begin
            r_hi    <= in_data;
            r_chk   <= w_chk_next;
            r_state <= DATA_LO;
          end
        end

        DATA_LO: begin
          if (w_accept) begin
            rom_we    <= 1'b1;
            rom_wdata <= {r_hi, in_data};
            r_chk     <= w_chk_next;
            r_count   <= r_count - (ADDR_W + 1)'(1);
            r_state   <= (r_count == (ADDR_W + 1)'(1)) ? CHECK : DATA_HI;
          end
        end

        CHECK: begin
          // Compare against the sum of everything before the CHK byte.
          if (w_accept) begin
            r_chk <= w_chk_next;
            if (in_data == r_chk) begin
              r_state   <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              r_state <= ERR;
              error   <= 1'b1;
            end
          end
        end

        DONE, ERR: begin
          // A fresh start byte re-arms the loader and reloads from address 0.
          if (w_accept && w_is_start) begin
            r_state   <= LEN_HI;
            r_chk     <= '0;
            r_count   <= '0;
            rom_addr  <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase

      // Stalled too long inside a frame: abort regardless of the current state.
      if (w_in_frame && !w_accept && (r_tmo == TMO_LAST)) begin
        r_state <= ERR;
        error   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_rom_loader
//
// Directed bench for hack_rom_loader, built with a 4-word ROM (ADDR_W=2) and a
// 16-cycle timeout so the oversize, full-ROM wrap and timeout cases are short.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, and ROM writes are captured on the falling edge.
// -----------------------------------------------------------------------------
module tb_hack_rom_loader;

  localparam int AW  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int checks   = 0;
  int failures = 0;

  // Captured writes as {addr, data}.
  logic [AW+15:0] wr_q[$];

  hack_rom_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rom_we) wr_q.push_back({rom_addr, rom_wdata});

  // One byte, accepted on the next rising edge; returns 1 unit after it.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Sends n bytes, most significant byte of 'bytes' first. With gap set, each
  // byte is preceded by 5 idle cycles carrying a start-byte pattern on in_data.
  task automatic send_seq(input logic [127:0] bytes, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        in_data = 8'hA5;
        repeat (5) @(posedge clk);
        #1;
      end
      send(bytes[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    #12;
    if ({in_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error} !==
        {1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got rdy/we/addr/wdata/cpu_rst/done/err=%b/%b/%h/%h/%b/%b/%b expected 1/0/0/0000/1/0/0",
               in_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error);
    end
    checks++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    wr_q.delete();
    send_seq(128'hA5_00_02_00_02_EC_10, 7, 1'b0);
    if ({cpu_reset, done, error} !== 3'b100) begin
      failures++;
      $display("FAIL good_before_chk: got cpu_rst/done/err=%b expected 100", {cpu_reset, done, error});
    end
    checks++;
    send(8'h00);
    if ({cpu_reset, done, error} !== 3'b010) begin
      failures++;
      $display("FAIL good_after_chk: got cpu_rst/done/err=%b expected 010", {cpu_reset, done, error});
    end
    checks++;
    if (rom_addr !== 2'd2) begin
      failures++;
      $display("FAIL good_final_addr: got %0d expected 2", rom_addr);
    end
    checks++;
    if (wr_q.size() !== 2 || wr_q[0] !== {2'd0, 16'h0002} || wr_q[1] !== {2'd1, 16'hEC10}) begin
      failures++;
      $display("FAIL good_writes: got %0d writes first=%h last=%h expected 2 writes 00002 1ec10",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 18'h0, (wr_q.size() > 1) ? wr_q[1] : 18'h0);
    end
    checks++;
  endtask

  task automatic test_bad_checksum;
    wr_q.delete();
    send(8'hA5);   // restart from DONE
    if ({cpu_reset, done, error, rom_addr} !== {3'b100, 2'd0}) begin
      failures++;
      $display("FAIL restart_from_done: got cpu_rst/done/err=%b addr=%0d expected 100 addr=0",
               {cpu_reset, done, error}, rom_addr);
    end
    checks++;
    send_seq(128'h00_02_00_02_EC_10_01, 7, 1'b0);
    if ({cpu_reset, done, error} !== 3'b101) begin
      failures++;
      $display("FAIL bad_chk_status: got cpu_rst/done/err=%b expected 101", {cpu_reset, done, error});
    end
    checks++;
    if (wr_q.size() !== 2 || wr_q[0] !== {2'd0, 16'h0002} || wr_q[1] !== {2'd1, 16'hEC10}) begin
      failures++;
      $display("FAIL bad_chk_writes: got %0d writes expected 2 (0:0002, 1:ec10)", wr_q.size());
    end
    checks++;
  endtask

  task automatic test_zero_length;
    wr_q.delete();
    send_seq(128'h3C_FF, 2, 1'b0);   // ignored while in ERR
    if ({cpu_reset, done, error} !== 3'b101) begin
      failures++;
      $display("FAIL err_ignores_garbage: got cpu_rst/done/err=%b expected 101", {cpu_reset, done, error});
    end
    checks++;
    send_seq(128'hA5_00_00_00, 4, 1'b0);
    if ({cpu_reset, done, error} !== 3'b010 || wr_q.size() !== 0) begin
      failures++;
      $display("FAIL zero_len: got cpu_rst/done/err=%b writes=%0d expected 010 writes=0",
               {cpu_reset, done, error}, wr_q.size());
    end
    checks++;
  endtask

  task automatic test_timeout;
    wr_q.delete();
    send_seq(128'hA5_00_01_00, 4, 1'b0);
    for (int i = 1; i < TMO; i++) begin
      @(posedge clk); #1;
      if (error !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early: error=%b after %0d idle cycles expected 0", error, i);
      end
      checks++;
    end
    @(posedge clk); #1;
    if ({cpu_reset, done, error} !== 3'b101 || wr_q.size() !== 0) begin
      failures++;
      $display("FAIL timeout_fire: got cpu_rst/done/err=%b writes=%0d expected 101 writes=0",
               {cpu_reset, done, error}, wr_q.size());
    end
    checks++;
  endtask

  task automatic test_oversize;
    wr_q.delete();
    send(8'hA5);   // restart from ERR
    if ({cpu_reset, done, error} !== 3'b100) begin
      failures++;
      $display("FAIL restart_from_err: got cpu_rst/done/err=%b expected 100", {cpu_reset, done, error});
    end
    checks++;
    send_seq(128'h00_05, 2, 1'b0);
    if ({cpu_reset, done, error} !== 3'b101 || wr_q.size() !== 0) begin
      failures++;
      $display("FAIL oversize_len: got cpu_rst/done/err=%b writes=%0d expected 101 writes=0",
               {cpu_reset, done, error}, wr_q.size());
    end
    checks++;
  endtask

  // LEN equal to the ROM size is legal and wraps rom_addr back to 0.
  task automatic test_full_rom;
    wr_q.delete();
    send_seq(128'hA5_00_04_12_34_56_78_9A_BC_DE_F0_3C, 12, 1'b0);
    if ({cpu_reset, done, error, rom_addr} !== {3'b010, 2'd0}) begin
      failures++;
      $display("FAIL full_rom_status: got cpu_rst/done/err=%b addr=%0d expected 010 addr=0",
               {cpu_reset, done, error}, rom_addr);
    end
    checks++;
    if (wr_q.size() !== 4 || wr_q[0] !== {2'd0, 16'h1234} || wr_q[1] !== {2'd1, 16'h5678} ||
        wr_q[2] !== {2'd2, 16'h9ABC} || wr_q[3] !== {2'd3, 16'hDEF0}) begin
      failures++;
      $display("FAIL full_rom_writes: got %0d writes expected 4 (0:1234 1:5678 2:9abc 3:def0)", wr_q.size());
    end
    checks++;
  endtask

  task automatic test_gapped;
    reset = 1'b1;
    #4;
    reset = 1'b0;
    @(posedge clk); #1;
    wr_q.delete();
    send_seq(128'h3C_FF, 2, 1'b1);
    if ({cpu_reset, done, error} !== 3'b100) begin
      failures++;
      $display("FAIL idle_garbage: got cpu_rst/done/err=%b expected 100", {cpu_reset, done, error});
    end
    checks++;
    send_seq(128'hA5_00_02_00_02_EC_10_00, 8, 1'b1);
    if ({cpu_reset, done, error, rom_addr} !== {3'b010, 2'd2}) begin
      failures++;
      $display("FAIL gapped_status: got cpu_rst/done/err=%b addr=%0d expected 010 addr=2",
               {cpu_reset, done, error}, rom_addr);
    end
    checks++;
    if (wr_q.size() !== 2 || wr_q[0] !== {2'd0, 16'h0002} || wr_q[1] !== {2'd1, 16'hEC10}) begin
      failures++;
      $display("FAIL gapped_writes: got %0d writes expected 2 (0:0002, 1:ec10)", wr_q.size());
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame;
    wr_q.delete();
    send_seq(128'hA5_00_02_00_02, 5, 1'b0);   // restart, first word written
    if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 2'd0, 16'h0002}) begin
      failures++;
      $display("FAIL first_word_strobe: got we/addr/wdata=%b/%0d/%h expected 1/0/0002", rom_we, rom_addr, rom_wdata);
    end
    checks++;
    #3;
    reset = 1'b1;
    #1;   // no clock edge since reset rose
    if ({rom_we, rom_addr, rom_wdata, cpu_reset, done, error} !== {1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got we/addr/wdata/cpu_rst/done/err=%b/%0d/%h/%b/%b/%b expected 0/0/0000/1/0/0",
               rom_we, rom_addr, rom_wdata, cpu_reset, done, error);
    end
    checks++;
    @(posedge clk); #4;
    reset = 1'b0;
    @(posedge clk); #1;
    wr_q.delete();
    send_seq(128'hA5_00_02_00_02_EC_10_00, 8, 1'b0);
    if ({cpu_reset, done, error, rom_addr} !== {3'b010, 2'd2} || wr_q.size() !== 2) begin
      failures++;
      $display("FAIL reload_after_reset: got cpu_rst/done/err=%b addr=%0d writes=%0d expected 010 addr=2 writes=2",
               {cpu_reset, done, error}, rom_addr, wr_q.size());
    end
    checks++;
    send(8'hA5);
    if ({cpu_reset, done, error, rom_addr} !== {3'b100, 2'd0}) begin
      failures++;
      $display("FAIL second_start: got cpu_rst/done/err=%b addr=%0d expected 100 addr=0",
               {cpu_reset, done, error}, rom_addr);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_length();
    test_timeout();
    test_oversize();
    test_full_rom();
    test_gapped();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
